// File: rtl/machina_pkg.sv
// Shared widths, Q-format constants and the loss_unit state encoding.
package machina_pkg;

  localparam int unsigned ACTIVATION_W = 8;
  localparam int unsigned ERROR_W      = 16;
  localparam int unsigned LOSS_W       = 16;
  localparam int unsigned FRAC         = 8;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    ERROR   = 2'd1,
    LOSS    = 2'd2
  } loss_state_e;

endpackage

// File: rtl/loss_unit_if.sv
// Operand, error and loss handshake bundle for loss_unit.
interface loss_unit_if;
  import machina_pkg::*;

  logic                    argument_valid;
  logic [ACTIVATION_W-1:0] argument_data;
  logic                    argument_ready;
  logic                    target_valid;
  logic [ACTIVATION_W-1:0] target_data;
  logic                    target_ready;
  logic                    error_valid;
  logic [ERROR_W-1:0]      error_data;
  logic                    error_ready;
  logic                    loss_valid;
  logic [LOSS_W-1:0]       loss_data;
  logic                    loss_ready;

  // master: the surrounding pipeline; slave: loss_unit itself
  modport master (
    output argument_valid, argument_data, target_valid, target_data,
    output error_ready, loss_ready,
    input  argument_ready, target_ready, error_valid, error_data,
    input  loss_valid, loss_data
  );

  modport slave (
    input  argument_valid, argument_data, target_valid, target_data,
    input  error_ready, loss_ready,
    output argument_ready, target_ready, error_valid, error_data,
    output loss_valid, loss_data
  );

endinterface

// File: rtl/loss_accumulator.sv
// Batch accumulator: running sum of squared errors, sample count and mean loss word.
module loss_accumulator
  import machina_pkg::*;
#(
  parameter int unsigned BATCH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              add_i,
  input  logic [LOSS_W-1:0] sq_i,
  input  logic              clear_i,
  output logic              last_c,
  output logic [LOSS_W-1:0] loss_data_o
);

  localparam int unsigned LOG_B = $clog2(BATCH);
  localparam int unsigned SUM_W = LOSS_W + LOG_B;
  localparam int unsigned CNT_W = (LOG_B > 0) ? LOG_B : 1;

  logic [SUM_W-1:0]  sum_q, sum_d;
  logic [SUM_W-1:0]  sum_add_c, mean_c;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [LOSS_W-1:0] loss_q, loss_d;

  assign last_c      = (count_q == CNT_W'(BATCH - 1));
  assign loss_data_o = loss_q;
  assign sum_add_c   = sum_q + SUM_W'(sq_i);
  assign mean_c      = sum_add_c >> LOG_B;

  always_comb begin
    sum_d   = sum_q;
    count_d = count_q;
    loss_d  = loss_q;
    if (clear_i) begin
      sum_d   = '0;
      count_d = '0;
    end else if (add_i) begin
      sum_d = sum_add_c;
      if (last_c) begin
        loss_d = (mean_c > SUM_W'({LOSS_W{1'b1}})) ? {LOSS_W{1'b1}} : LOSS_W'(mean_c);
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sum_q   <= '0;
      count_q <= '0;
      loss_q  <= '0;
    end else begin
      sum_q   <= sum_d;
      count_q <= count_d;
      loss_q  <= loss_d;
    end
  end

endmodule

// File: rtl/loss_unit.sv
// Compares activation result with target, returns a Q8.8 error and reports batch mean squared error.
module loss_unit
  import machina_pkg::*;
#(
  parameter int unsigned SHIFT = 0,
  parameter int unsigned BATCH = 4
) (
  input  logic  clock,
  input  logic  reset,
  loss_unit_if.slave bus
);

  localparam int unsigned PAD_W = ERROR_W - ACTIVATION_W;

  loss_state_e             state_q, state_d;
  logic                    have_arg_q, have_arg_d;
  logic                    have_tgt_q, have_tgt_d;
  logic [ACTIVATION_W-1:0] arg_q, arg_d;
  logic [ACTIVATION_W-1:0] tgt_q, tgt_d;
  logic                    err_valid_q, err_valid_d;
  logic [ERROR_W-1:0]      err_q, err_d;
  logic [LOSS_W-1:0]       sq_q, sq_d;
  logic                    loss_valid_q, loss_valid_d;

  logic                    arg_rdy_c, tgt_rdy_c, arg_hs_c, tgt_hs_c;
  logic [ACTIVATION_W-1:0] arg_cur_c, tgt_cur_c;
  logic signed [ERROR_W-1:0]   diff_c, err_shift_c;
  logic signed [2*ERROR_W-1:0] prod_c;
  logic                    acc_add_c, acc_clear_c, acc_last_c;

  assign arg_rdy_c = (state_q == CAPTURE) && !have_arg_q;
  assign tgt_rdy_c = (state_q == CAPTURE) && !have_tgt_q;
  assign arg_hs_c  = bus.argument_valid && arg_rdy_c;
  assign tgt_hs_c  = bus.target_valid && tgt_rdy_c;

  assign bus.argument_ready = arg_rdy_c;
  assign bus.target_ready   = tgt_rdy_c;
  assign bus.error_valid    = err_valid_q;
  assign bus.error_data     = err_q;
  assign bus.loss_valid     = loss_valid_q;

  // Operands arriving this cycle bypass the holding registers
  assign arg_cur_c   = have_arg_q ? arg_q : bus.argument_data;
  assign tgt_cur_c   = have_tgt_q ? tgt_q : bus.target_data;
  assign diff_c      = $signed({{PAD_W{1'b0}}, tgt_cur_c}) - $signed({{PAD_W{1'b0}}, arg_cur_c});
  assign err_shift_c = diff_c <<< SHIFT;
  assign prod_c      = (2*ERROR_W)'(diff_c) * (2*ERROR_W)'(diff_c);

  always_comb begin
    state_d      = state_q;
    have_arg_d   = have_arg_q;
    have_tgt_d   = have_tgt_q;
    arg_d        = arg_q;
    tgt_d        = tgt_q;
    err_valid_d  = err_valid_q;
    err_d        = err_q;
    sq_d         = sq_q;
    loss_valid_d = loss_valid_q;
    acc_add_c    = 1'b0;
    acc_clear_c  = 1'b0;
    case (state_q)
      CAPTURE: begin
        if (arg_hs_c) begin
          arg_d      = bus.argument_data;
          have_arg_d = 1'b1;
        end
        if (tgt_hs_c) begin
          tgt_d      = bus.target_data;
          have_tgt_d = 1'b1;
        end
        if ((have_arg_q || arg_hs_c) && (have_tgt_q || tgt_hs_c)) begin
          err_d       = ERROR_W'(err_shift_c);
          sq_d        = LOSS_W'(prod_c);
          err_valid_d = 1'b1;
          have_arg_d  = 1'b0;
          have_tgt_d  = 1'b0;
          state_d     = ERROR;
        end
      end
      ERROR: begin
        if (bus.error_ready) begin
          err_valid_d = 1'b0;
          acc_add_c   = 1'b1;
          if (acc_last_c) begin
            loss_valid_d = 1'b1;
            state_d      = LOSS;
          end else begin
            state_d = CAPTURE;
          end
        end
      end
      LOSS: begin
        if (bus.loss_ready) begin
          loss_valid_d = 1'b0;
          acc_clear_c  = 1'b1;
          state_d      = CAPTURE;
        end
      end
      default: state_d = CAPTURE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= CAPTURE;
      have_arg_q   <= 1'b0;
      have_tgt_q   <= 1'b0;
      arg_q        <= '0;
      tgt_q        <= '0;
      err_valid_q  <= 1'b0;
      err_q        <= '0;
      sq_q         <= '0;
      loss_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      have_arg_q   <= have_arg_d;
      have_tgt_q   <= have_tgt_d;
      arg_q        <= arg_d;
      tgt_q        <= tgt_d;
      err_valid_q  <= err_valid_d;
      err_q        <= err_d;
      sq_q         <= sq_d;
      loss_valid_q <= loss_valid_d;
    end
  end

  loss_accumulator #(.BATCH(BATCH)) u_acc (
    .clock       (clock),
    .reset       (reset),
    .add_i       (acc_add_c),
    .sq_i        (sq_q),
    .clear_i     (acc_clear_c),
    .last_c      (acc_last_c),
    .loss_data_o (bus.loss_data)
  );

endmodule

// File: tb/tb_loss_unit.sv
// Randomized self-checking bench for loss_unit across three SHIFT/BATCH configurations.
module tb_loss_unit;

  logic clock;
  logic reset;
  int   sel;

  logic       drv_av, drv_tv, drv_er, drv_lr;
  logic [7:0] drv_ad, drv_td;

  logic        o_ar, o_tr, o_ev, o_lv;
  logic [15:0] o_ed, o_ld;

  int n_chk;
  int n_err;

  int shift_a [3] = '{0, 2, 0};
  int batch_a [3] = '{4, 4, 1};
  longint sum_m [3];
  int     n_m   [3];

  loss_unit_if bus0 ();
  loss_unit_if bus1 ();
  loss_unit_if bus2 ();

  loss_unit #(.SHIFT(0), .BATCH(4)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
  loss_unit #(.SHIFT(2), .BATCH(4)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
  loss_unit #(.SHIFT(0), .BATCH(1)) dut2 (.clock(clock), .reset(reset), .bus(bus2));

  assign bus0.argument_valid = drv_av && (sel == 0);
  assign bus0.target_valid   = drv_tv && (sel == 0);
  assign bus0.error_ready    = drv_er && (sel == 0);
  assign bus0.loss_ready     = drv_lr && (sel == 0);
  assign bus0.argument_data  = drv_ad;
  assign bus0.target_data    = drv_td;
  assign bus1.argument_valid = drv_av && (sel == 1);
  assign bus1.target_valid   = drv_tv && (sel == 1);
  assign bus1.error_ready    = drv_er && (sel == 1);
  assign bus1.loss_ready     = drv_lr && (sel == 1);
  assign bus1.argument_data  = drv_ad;
  assign bus1.target_data    = drv_td;
  assign bus2.argument_valid = drv_av && (sel == 2);
  assign bus2.target_valid   = drv_tv && (sel == 2);
  assign bus2.error_ready    = drv_er && (sel == 2);
  assign bus2.loss_ready     = drv_lr && (sel == 2);
  assign bus2.argument_data  = drv_ad;
  assign bus2.target_data    = drv_td;

  always_comb begin
    case (sel)
      1: begin
        o_ar = bus1.argument_ready; o_tr = bus1.target_ready;
        o_ev = bus1.error_valid;    o_ed = bus1.error_data;
        o_lv = bus1.loss_valid;     o_ld = bus1.loss_data;
      end
      2: begin
        o_ar = bus2.argument_ready; o_tr = bus2.target_ready;
        o_ev = bus2.error_valid;    o_ed = bus2.error_data;
        o_lv = bus2.loss_valid;     o_ld = bus2.loss_data;
      end
      default: begin
        o_ar = bus0.argument_ready; o_tr = bus0.target_ready;
        o_ev = bus0.error_valid;    o_ed = bus0.error_data;
        o_lv = bus0.loss_valid;     o_ld = bus0.loss_data;
      end
    endcase
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s dut=%0d got=%h exp=%h t=%0t", tag, sel, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 3; i++) begin
      sum_m[i] = 0;
      n_m[i]   = 0;
    end
  endtask

  // order: 0 = both together, 1 = target leads, 2 = argument leads
  task automatic do_sample(input int a, input int t, input int order, input int lead,
                           input int er_wait, input int lr_wait);
    int          d;
    logic [15:0] exp_err;
    longint      mean;
    d       = t - a;
    exp_err = 16'(d * (1 << shift_a[sel]));
    check("cap_rdy", 32'({o_ar, o_tr}), 3);
    if (order == 0) begin
      drv_av = 1'b1; drv_ad = 8'(a);
      drv_tv = 1'b1; drv_td = 8'(t);
      step();
      drv_av = 1'b0; drv_tv = 1'b0;
    end else begin
      if (order == 1) begin
        drv_tv = 1'b1; drv_td = 8'(t);
      end else begin
        drv_av = 1'b1; drv_ad = 8'(a);
      end
      step();
      drv_av = 1'b0; drv_tv = 1'b0;
      check("half_rdy", 32'({o_ar, o_tr}), (order == 1) ? 2 : 1);
      for (int i = 0; i < lead; i++) begin
        drv_ad = 8'($urandom); drv_td = 8'($urandom);
        step();
        check("early_ev", 32'(o_ev), 0);
        check("half_rdy_hold", 32'({o_ar, o_tr}), (order == 1) ? 2 : 1);
      end
      if (order == 1) begin
        drv_av = 1'b1; drv_ad = 8'(a);
      end else begin
        drv_tv = 1'b1; drv_td = 8'(t);
      end
      step();
      drv_av = 1'b0; drv_tv = 1'b0;
    end
    check("err_valid", 32'(o_ev), 1);
    check("err_data", 32'(o_ed), 32'(exp_err));
    check("err_rdy_low", 32'({o_ar, o_tr}), 0);
    for (int i = 0; i < er_wait; i++) begin
      drv_av = 1'b1; drv_tv = 1'b1;
      drv_ad = 8'($urandom); drv_td = 8'($urandom);
      step();
      check("err_hold_v", 32'(o_ev), 1);
      check("err_hold_d", 32'(o_ed), 32'(exp_err));
      check("err_hold_rdy", 32'({o_ar, o_tr}), 0);
    end
    drv_av = 1'b0; drv_tv = 1'b0; drv_er = 1'b1;
    step();
    drv_er = 1'b0;
    check("err_drop", 32'(o_ev), 0);
    sum_m[sel] += longint'(d * d);
    n_m[sel]++;
    if (n_m[sel] == batch_a[sel]) begin
      mean = sum_m[sel] / batch_a[sel];
      if (mean > 65535) mean = 65535;
      check("loss_valid", 32'(o_lv), 1);
      check("loss_data", 32'(o_ld), 32'(mean));
      check("loss_rdy_low", 32'({o_ar, o_tr}), 0);
      for (int i = 0; i < lr_wait; i++) begin
        drv_av = 1'b1; drv_tv = 1'b1;
        drv_ad = 8'($urandom); drv_td = 8'($urandom);
        step();
        check("loss_hold_v", 32'(o_lv), 1);
        check("loss_hold_d", 32'(o_ld), 32'(mean));
        check("loss_hold_rdy", 32'({o_ar, o_tr}), 0);
      end
      drv_av = 1'b0; drv_tv = 1'b0; drv_lr = 1'b1;
      step();
      drv_lr = 1'b0;
      check("loss_drop", 32'(o_lv), 0);
      sum_m[sel] = 0;
      n_m[sel]   = 0;
    end else begin
      check("no_loss", 32'(o_lv), 0);
    end
  endtask

  initial begin
    n_chk = 0; n_err = 0; sel = 0;
    drv_av = 1'b0; drv_tv = 1'b0; drv_er = 1'b0; drv_lr = 1'b0;
    drv_ad = '0; drv_td = '0;
    clear_model();
    reset = 1'b0;
    #1;
    check("rst_rdy", 32'({o_ar, o_tr}), 3);
    check("rst_ev", 32'(o_ev), 0);
    check("rst_lv", 32'(o_lv), 0);
    check("rst_ed", 32'(o_ed), 0);
    check("rst_ld", 32'(o_ld), 0);
    #11;
    reset = 1'b1;

    // BATCH=4 differences +1,-2,+3,-4 then an all-zero batch
    sel = 0;
    do_sample(10, 11, 0, 0, 0, 0);
    do_sample(12, 10, 0, 0, 1, 0);
    do_sample(0, 3, 0, 0, 0, 0);
    do_sample(4, 0, 0, 0, 0, 2);
    for (int i = 0; i < 4; i++) do_sample(85, 85, 0, 0, 0, 0);
    do_sample(8'h80, 8'hFF, 0, 0, 0, 0);
    do_sample(8'h40, 8'h20, 1, 3, 5, 0);
    do_sample(8'h00, 8'hFF, 2, 2, 0, 0);
    do_sample(8'hFF, 8'hFF, 0, 0, 0, 1);

    sel = 1;
    do_sample(8'hFF, 8'h00, 0, 0, 0, 0);
    do_sample(8'h00, 8'hFF, 1, 1, 2, 0);

    sel = 2;
    do_sample(8'hFF, 8'h00, 0, 0, 0, 4);
    do_sample(8'h00, 8'h00, 2, 3, 1, 0);

    for (int k = 0; k < 48; k++) begin
      sel = k % 3;
      do_sample(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    // Reset mid-ERROR with two samples already accumulated
    sel = 0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    clear_model();
    step();
    do_sample(1, 9, 0, 0, 0, 0);
    do_sample(9, 1, 0, 0, 0, 0);
    drv_av = 1'b1; drv_ad = 8'd0; drv_tv = 1'b1; drv_td = 8'd200;
    step();
    drv_av = 1'b0; drv_tv = 1'b0;
    check("pre_rst_ev", 32'(o_ev), 1);
    step();
    reset = 1'b0;
    #1;
    check("midrst_ev", 32'(o_ev), 0);
    check("midrst_ed", 32'(o_ed), 0);
    check("midrst_lv", 32'(o_lv), 0);
    check("midrst_rdy", 32'({o_ar, o_tr}), 3);
    step();
    reset = 1'b1;
    clear_model();
    step();
    check("postrst_ev", 32'(o_ev), 0);
    check("postrst_lv", 32'(o_lv), 0);
    for (int i = 0; i < 4; i++) do_sample(10, 15, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
